// File: rtl/connect_pkg.sv
// Purpose: shared types and flit-layout helpers for the CONNECT injection/ejection endpoints.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package connect_pkg;

    // Packetizer control state: waiting for a message, or streaming one out.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Flit layout, MSB to LSB: {valid, tail, dest, vc, data}
    function automatic int flit_width(input int data_w, input int dest_w, input int vc_w);
        return 2 + data_w + dest_w + vc_w;
    endfunction

    function automatic int vc_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int dest_lsb(input int data_w, input int vc_w);
        return data_w + vc_w;
    endfunction

    function automatic int tail_bit(input int data_w, input int dest_w, input int vc_w);
        return data_w + vc_w + dest_w;
    endfunction

    function automatic int valid_bit(input int data_w, input int dest_w, input int vc_w);
        return data_w + vc_w + dest_w + 1;
    endfunction

endpackage

// File: rtl/connect_vc_blackout.sv
// Purpose: per-VC "issued last cycle" tracker that masks the peeked non-full bitmap.
// Latency: permit is combinational from nonfull_vcs; the blackout register updates at the next edge.
// Backpressure: a VC that just carried a flit is withheld for one cycle to cover peek-status lag.
module connect_vc_blackout #(
    parameter int NUM_VCS = 2,
    parameter int VC_BITS = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               issue_en,
    input  logic [VC_BITS-1:0] issue_vc,
    input  logic [NUM_VCS-1:0] nonfull_vcs,
    output logic [NUM_VCS-1:0] permit_vcs
);

    logic [NUM_VCS-1:0] issued_q;

    // Remember which VC (if any) carried a flit in the cycle just ending.
    always_ff @(posedge CLK) begin
        if (RST) begin
            issued_q <= '0;
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                issued_q[v] <= issue_en && (issue_vc == VC_BITS'(v));
            end
        end
    end

    assign permit_vcs = nonfull_vcs & ~issued_q;

endmodule

// File: rtl/connect_peek_packetizer.sv
// Purpose: serialise whole messages into head/body/tail flits for one CONNECT Peek send port.
// Latency: head flit is driven combinationally in the cycle after the accepting edge; at most one flit per VC every 2 cycles.
// Backpressure: msg_ready drops while a packet is in flight; flits wait on nonfull_vcs[vc] and the per-VC blackout.
module connect_peek_packetizer
    import connect_pkg::*;
#(
    parameter int FLIT_DATA_WIDTH = 32,
    parameter int DEST_BITS       = 1,
    parameter int VC_BITS         = 1,
    parameter int NUM_VCS         = 2,
    parameter int MAX_FLITS       = 4,
    parameter int LEN_BITS        = 2
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic                                 msg_valid,
    output logic                                 msg_ready,
    input  logic [DEST_BITS-1:0]                 msg_dest,
    input  logic [VC_BITS-1:0]                   msg_vc,
    input  logic [LEN_BITS-1:0]                  msg_len_m1,
    input  logic [MAX_FLITS*FLIT_DATA_WIDTH-1:0] msg_payload,
    input  logic [NUM_VCS-1:0]                   nonfull_vcs,
    output logic                                 nonfull_en,
    output logic [flit_width(FLIT_DATA_WIDTH, DEST_BITS, VC_BITS)-1:0] flit_out,
    output logic                                 flit_en,
    output logic [31:0]                          pkt_count,
    output logic [31:0]                          stall_count
);

    localparam int VALID_BIT = valid_bit(FLIT_DATA_WIDTH, DEST_BITS, VC_BITS);
    localparam int TAIL_BIT  = tail_bit(FLIT_DATA_WIDTH, DEST_BITS, VC_BITS);
    localparam int DEST_LSB  = dest_lsb(FLIT_DATA_WIDTH, VC_BITS);
    localparam int VC_LSB    = vc_lsb(FLIT_DATA_WIDTH);

    state_t                           state_q, state_d;
    logic [DEST_BITS-1:0]             dest_q;
    logic [VC_BITS-1:0]               vc_q;
    logic [LEN_BITS-1:0]              len_q;
    logic [LEN_BITS-1:0]              idx_q;
    logic [MAX_FLITS*FLIT_DATA_WIDTH-1:0] payload_q;

    logic [NUM_VCS-1:0]               permit;
    logic [FLIT_DATA_WIDTH-1:0]       beat;
    logic                             tail;
    logic                             issue;
    logic                             accept;

    connect_vc_blackout #(
        .NUM_VCS (NUM_VCS),
        .VC_BITS (VC_BITS)
    ) u_blackout (
        .CLK         (CLK),
        .RST         (RST),
        .issue_en    (issue),
        .issue_vc    (vc_q),
        .nonfull_vcs (nonfull_vcs),
        .permit_vcs  (permit)
    );

    assign beat       = payload_q[int'(idx_q)*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH];
    assign tail       = (idx_q == len_q);
    assign accept     = msg_valid && msg_ready;
    // Peek status is polled continuously once out of reset.
    assign nonfull_en = !RST;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: enter SEND on accept, stay there on back-to-back tail/accept.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (msg_valid) state_d = SEND;
            SEND:    if (issue && tail && !msg_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: flit issue gated by permit, ready only when idle or on the tail cycle.
    always_comb begin
        msg_ready = 1'b0;
        issue     = 1'b0;
        flit_en   = 1'b0;
        flit_out  = '0;
        if (!RST) begin
            case (state_q)
                IDLE: msg_ready = 1'b1;
                SEND: begin
                    issue = permit[vc_q];
                    if (issue) begin
                        flit_en                            = 1'b1;
                        flit_out[VALID_BIT]                = 1'b1;
                        flit_out[TAIL_BIT]                 = tail;
                        flit_out[DEST_LSB +: DEST_BITS]    = dest_q;
                        flit_out[VC_LSB +: VC_BITS]        = vc_q;
                        flit_out[FLIT_DATA_WIDTH-1:0]      = beat;
                        msg_ready                          = tail;
                    end
                end
                default: ;
            endcase
        end
    end

    // Message holding register and beat index; a new accept always restarts at beat 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dest_q    <= '0;
            vc_q      <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            payload_q <= '0;
        end else if (accept) begin
            dest_q    <= msg_dest;
            vc_q      <= msg_vc;
            len_q     <= msg_len_m1;
            idx_q     <= '0;
            payload_q <= msg_payload;
        end else if (issue) begin
            idx_q     <= idx_q + LEN_BITS'(1);
        end
    end

    // Completed-packet and stalled-cycle counters, free-running modulo 2^32.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pkt_count   <= '0;
            stall_count <= '0;
        end else begin
            if (issue && tail) pkt_count <= pkt_count + 32'd1;
            if ((state_q == SEND) && !issue) stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_connect_peek_packetizer.sv
// Purpose: randomized and directed check of connect_peek_packetizer against a packet-queue model.
// Latency: inputs change 1 time unit after each rising edge; outputs are sampled on the falling edge.
// Backpressure: nonfull_vcs is driven directly to exercise stalls and the per-VC blackout.
module tb_connect_peek_packetizer;

    localparam int FDW = 32;
    localparam int DB  = 1;
    localparam int VB  = 1;
    localparam int NV  = 2;
    localparam int MF  = 4;
    localparam int LB  = 2;
    localparam int FW  = 2 + FDW + DB + VB;

    logic              CLK = 1'b0;
    logic              RST;
    logic              msg_valid;
    logic              msg_ready;
    logic [DB-1:0]     msg_dest;
    logic [VB-1:0]     msg_vc;
    logic [LB-1:0]     msg_len_m1;
    logic [MF*FDW-1:0] msg_payload;
    logic [NV-1:0]     nonfull_vcs;
    logic              nonfull_en;
    logic [FW-1:0]     flit_out;
    logic              flit_en;
    logic [31:0]       pkt_count;
    logic [31:0]       stall_count;

    always #5 CLK = ~CLK;

    connect_peek_packetizer #(
        .FLIT_DATA_WIDTH (FDW),
        .DEST_BITS       (DB),
        .VC_BITS         (VB),
        .NUM_VCS         (NV),
        .MAX_FLITS       (MF),
        .LEN_BITS        (LB)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .msg_valid   (msg_valid),
        .msg_ready   (msg_ready),
        .msg_dest    (msg_dest),
        .msg_vc      (msg_vc),
        .msg_len_m1  (msg_len_m1),
        .msg_payload (msg_payload),
        .nonfull_vcs (nonfull_vcs),
        .nonfull_en  (nonfull_en),
        .flit_out    (flit_out),
        .flit_en     (flit_en),
        .pkt_count   (pkt_count),
        .stall_count (stall_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: the packet in flight is a queue of finished flit words.
    bit            m_busy;
    logic [FW-1:0] m_q[$];
    int            m_vc;
    bit            m_prev[NV];
    logic [31:0]   m_pkt;
    logic [31:0]   m_stall;

    logic [FW-1:0] obs_flit;
    logic          obs_en;
    logic          obs_rdy;

    task automatic model_reset();
        m_busy  = 0;
        m_q.delete();
        for (int v = 0; v < NV; v++) m_prev[v] = 0;
        m_pkt   = 0;
        m_stall = 0;
    endtask

    // One clock: compare outputs on the falling edge, then advance the model across the rising edge.
    task automatic cycle();
        bit            issue;
        bit            last;
        bit            exp_rdy;
        logic [FW-1:0] exp_flit;
        @(negedge CLK);
        obs_flit = flit_out;
        obs_en   = flit_en;
        obs_rdy  = msg_ready;
        if (RST) begin
            check_val("rst_flit_en", flit_en, 0);
            check_val("rst_flit_out", flit_out, 0);
            check_val("rst_msg_ready", msg_ready, 0);
            check_val("rst_nonfull_en", nonfull_en, 0);
            @(posedge CLK);
            model_reset();
            #1;
            return;
        end
        issue    = m_busy && nonfull_vcs[m_vc] && !m_prev[m_vc];
        last     = issue && (m_q.size() == 1);
        exp_rdy  = !m_busy || last;
        exp_flit = '0;
        if (issue) exp_flit = m_q[0];
        check_val("flit_en", flit_en, issue);
        check_val("flit_out", flit_out, exp_flit);
        check_val("msg_ready", msg_ready, exp_rdy);
        check_val("nonfull_en", nonfull_en, 1);
        check_val("pkt_count", pkt_count, m_pkt);
        check_val("stall_count", stall_count, m_stall);
        @(posedge CLK);
        for (int v = 0; v < NV; v++) m_prev[v] = issue && (v == m_vc);
        if (m_busy && !issue) m_stall++;
        if (issue) begin
            void'(m_q.pop_front());
            if (last) begin
                m_pkt++;
                m_busy = 0;
            end
        end
        if (msg_valid && exp_rdy) begin
            m_vc = int'(msg_vc);
            for (int k = 0; k <= int'(msg_len_m1); k++)
                m_q.push_back({1'b1, (k == int'(msg_len_m1)), msg_dest, msg_vc, msg_payload[k*FDW +: FDW]});
            m_busy = 1;
        end
        #1;
    endtask

    task automatic set_msg(input int dest, input int vc, input int len_m1,
                           input logic [31:0] b0, input logic [31:0] b1,
                           input logic [31:0] b2, input logic [31:0] b3);
        msg_valid   = 1'b1;
        msg_dest    = DB'(dest);
        msg_vc      = VB'(vc);
        msg_len_m1  = LB'(len_m1);
        msg_payload = {b3, b2, b1, b0};
    endtask

    logic [31:0] stall_before;

    initial begin
        RST         = 1'b1;
        msg_valid   = 1'b0;
        msg_dest    = '0;
        msg_vc      = '0;
        msg_len_m1  = '0;
        msg_payload = '0;
        nonfull_vcs = 2'b11;
        model_reset();
        @(posedge CLK);
        #1;
        cycle();
        cycle();
        RST = 1'b0;

        // Reset state seen in the first cycle after release.
        cycle();
        check_val("post_rst_ready", obs_rdy, 1);
        check_val("post_rst_pkt", pkt_count, 0);

        // 2-flit packet, dest=1, vc=0.
        set_msg(1, 0, 1, 32'hA, 32'hB, 32'h0, 32'h0);
        cycle();
        msg_valid = 1'b0;
        cycle();
        check_val("t1_head", obs_flit, 64'hA_0000_000A);
        cycle();
        check_val("t1_gap_en", obs_en, 0);
        cycle();
        check_val("t1_tail", obs_flit, 64'hE_0000_000B);
        check_val("t1_pkt", pkt_count, 1);
        check_val("t1_stall", stall_count, 1);

        // Single-flit packet, dest=0, vc=1.
        set_msg(0, 1, 0, 32'h5, 32'h0, 32'h0, 32'h0);
        cycle();
        msg_valid = 1'b0;
        cycle();
        check_val("t2_flit", obs_flit, 64'hD_0000_0005);
        check_val("t2_ready", obs_rdy, 1);

        // 4-flit packet on vc=0 with VC0 full for four cycles mid-packet.
        set_msg(0, 0, 3, 32'h100, 32'h101, 32'h102, 32'h103);
        cycle();
        msg_valid = 1'b0;
        cycle();
        stall_before = stall_count;
        nonfull_vcs = 2'b10;
        repeat (4) cycle();
        check_val("t3_stall_held", stall_count - stall_before, 4);
        nonfull_vcs = 2'b11;
        repeat (8) cycle();

        // Back-to-back vc=0 then vc=1 with msg_valid held high.
        set_msg(1, 0, 1, 32'h200, 32'h201, 32'h0, 32'h0);
        cycle();
        set_msg(1, 1, 1, 32'h300, 32'h301, 32'h0, 32'h0);
        cycle();
        cycle();
        cycle();
        check_val("t4_tail_ready", obs_rdy, 1);
        msg_valid = 1'b0;
        cycle();
        check_val("t4_b_head_en", obs_en, 1);
        check_val("t4_b_head", obs_flit, 64'hB_0000_0300);
        repeat (4) cycle();

        // Reset one cycle after the head of a 3-flit packet.
        set_msg(0, 0, 2, 32'h400, 32'h401, 32'h402, 32'h0);
        cycle();
        msg_valid = 1'b0;
        cycle();
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        cycle();
        check_val("t5_en_after_rst", obs_en, 0);
        check_val("t5_pkt_after_rst", pkt_count, 0);
        check_val("t5_stall_after_rst", stall_count, 0);
        set_msg(1, 1, 2, 32'h500, 32'h501, 32'h502, 32'h0);
        cycle();
        msg_valid = 1'b0;
        cycle();
        check_val("t5_fresh_head_en", obs_en, 1);
        check_val("t5_fresh_head_tail", obs_flit[FW-2], 0);
        repeat (6) cycle();

        // Permanently full network.
        nonfull_vcs = 2'b00;
        set_msg(0, 1, 1, 32'h600, 32'h601, 32'h0, 32'h0);
        cycle();
        stall_before = stall_count;
        repeat (10) begin
            cycle();
            check_val("t6_ready_low", obs_rdy, 0);
            check_val("t6_no_flit", obs_en, 0);
        end
        check_val("t6_stall", stall_count - stall_before, 10);
        msg_valid   = 1'b0;
        nonfull_vcs = 2'b11;
        repeat (6) cycle();

        // Randomized traffic, back-pressure and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            msg_valid   = ($urandom_range(0, 2) != 0);
            msg_dest    = DB'($urandom);
            msg_vc      = VB'($urandom);
            msg_len_m1  = LB'($urandom);
            msg_payload = {$urandom, $urandom, $urandom, $urandom};
            nonfull_vcs = ($urandom_range(0, 3) == 0) ? NV'($urandom) : 2'b11;
            RST         = ($urandom_range(0, 299) == 0);
            cycle();
        end
        RST       = 1'b0;
        msg_valid = 1'b0;
        repeat (4) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
